hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Parametrised hazard/forwarding unit for the Riscv151 pipeline. Replaces the fixed two-stage bypass logic.
//  Tracks in-flight writers in a destination scoreboard and selects a forwarding source per operand.
//  Stalls the decode (I) stage on load-use hazards. Squashes younger instructions after a redirect.
//  Sits beside control: it consumes decoded I-stage fields and drives the bypass muxes and stall/kill into the datapath.
// PARAMETERS
//  NUM_STAGES  2   tracked stages after I (1=X, 2=M, ...); stages beyond this are visible through the regfile
//  NUM_SRC     2   source operands per instruction
//  AW          5   register address width
//  LOAD_LAT    1   load data usable only from stage LOAD_LAT+1 onward; legal range 1..NUM_STAGES-1
//  KILL_SLOTS  1   consecutive cycles kill stays high per redirect; range 1..7
//  CNT_W       16  width of the performance counters
//  SELW = $clog2(NUM_STAGES+1), derived localparam
// PORTS
//  clk         in   1             rising-edge clock
//  reset       in   1             synchronous, active-high
//  id_valid    in   1             I-stage holds a real instruction
//  id_rs       in   NUM_SRC*AW    source register addresses; operand n at [n*AW +: AW]
//  id_rs_used  in   NUM_SRC       operand n is actually read
//  id_rd       in   AW            destination register
//  id_rd_we    in   1             instruction writes rd
//  id_is_load  in   1             instruction is a load
//  redirect    in   1             X-stage branch taken or jump (from control)
//  stall       out  1             hold PC and I-stage; insert a bubble into X
//  kill        out  1             squash the I-stage instruction (becomes a nop)
//  fwd_sel     out  NUM_SRC*SELW  per operand: 0=regfile, k=stage k result
//  stall_cnt   out  CNT_W         count of stall cycles, saturating
//  kill_cnt    out  CNT_W         count of kill cycles, saturating
// BEHAVIOUR
//  Scoreboard
//   - One entry per stage 1..NUM_STAGES, each holding {v, rd, we, ld}. All entries shift one stage per clock.
//   - Entry 1 loads {id_valid & ~stall & ~kill, id_rd, id_rd_we, id_is_load}. A stall or kill inserts a bubble (v=0).
//   - The entry leaving stage NUM_STAGES is dropped. The regfile is write-before-read, so no forwarding is needed after that.
//  Hit detection (combinational, per operand n)
//   - hit(k) = v & we & rd==rs_n & rs_n!=0 & id_rs_used[n].
//   - The youngest hit (smallest k) wins. fwd_sel_n = k, or 0 if there is no hit.
//  Load-use stall
//   - stall = id_valid & ~kill & (some operand's winning hit is an ld entry at k<=LOAD_LAT).
//   - While stall is high, fwd_sel is don't-care.
//   - Stall persists until the load reaches stage LOAD_LAT+1. At that point fwd_sel = LOAD_LAT+1 with no extra cycle.
//  Redirect and kill
//   - redirect is honoured only when entry 1 is valid; otherwise it is ignored.
//   - An honoured redirect raises kill in the same cycle.
//   - kcnt loads KILL_SLOTS-1; kill = honoured redirect | (kcnt!=0). kcnt decrements each cycle while non-zero.
//   - A new honoured redirect while kcnt!=0 reloads kcnt.
//   - Redirect has priority over stall: when kill=1, stall=0 and the pending load-use is dropped with the squashed instruction.
//  Counters
//   - stall_cnt increments on every cycle with stall=1; kill_cnt increments on every cycle with kill=1.
//   - Both saturate at all-ones.
//  Reset
//   - All entries v=0, kcnt=0, counters=0.
//   - The cycle after reset: stall=0, kill=0, fwd_sel=0.
//   - Asserting reset mid-stall or mid-kill clears everything on the next edge, and no state survives.
//  Zero register
//   - x0 never hits. A write to x0 still occupies an entry but is never forwarded.
// TESTING
//  1. reset, then add x5 followed by add x6,x5,x5 -> fwd_sel={1,1}, stall=0. One cycle later the next reader gets fwd_sel=2.
//  2. lw x7, then use of x7 (NUM_STAGES=2, LOAD_LAT=1) -> stall=1 for exactly 1 cycle, then fwd_sel=2, stall_cnt=1.
//  3. lw x7, then add x8,x7 with id_rs_used[1]=0 on x7 -> stall only if operand 0 matches; an unused operand never stalls.
//  4. Branch in X with redirect=1 while I holds a load-use consumer -> kill=1, stall=0, next entry 1 v=0, kill_cnt=1.
//  5. KILL_SLOTS=3: redirect pulse -> kill high for 3 cycles. A redirect in cycle 2 from a valid entry restarts the window.
//  6. Writes to x0 -> fwd_sel=0. Also: reset asserted during a stall -> stall=0 and fwd_sel=0 on the next cycle.
//  7. Force stall_cnt to all-ones (CNT_W=4, 16 stalls) -> the counter holds at 15.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | hazard_fwd_unit : destination scoreboard, operand bypass select,            |
// |                   load-use stall and redirect kill for the Riscv151 pipe    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module hazard_fwd_unit #(
  parameter int NUM_STAGES = 2,
  parameter int NUM_SRC    = 2,
  parameter int AW         = 5,
  parameter int LOAD_LAT   = 1,
  parameter int KILL_SLOTS = 1,
  parameter int CNT_W      = 16,
  localparam int SELW      = $clog2(NUM_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NUM_SRC*AW-1:0]    id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [AW-1:0]            id_rd,
  input  logic                     id_rd_we,
  input  logic                     id_is_load,
  input  logic                     redirect,
  output logic                     stall,
  output logic                     kill,
  output logic [NUM_SRC*SELW-1:0]  fwd_sel,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         kill_cnt
);

  localparam int              KW    = 3;
  localparam logic [KW-1:0]   KLOAD = KW'(KILL_SLOTS - 1);

  logic [NUM_STAGES:1]     r_v;
  logic [NUM_STAGES:1]     r_we;
  logic [NUM_STAGES:1]     r_ld;
  logic [AW-1:0]           r_rd [1:NUM_STAGES];
  logic [KW-1:0]           r_kcnt;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic [CNT_W-1:0]        r_kill_cnt;

  logic                    w_redir;
  logic                    w_kill;
  logic                    w_stall;
  logic [NUM_SRC-1:0]      w_ld_hz;
  logic [NUM_SRC*SELW-1:0] w_sel;

  // Scan oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    w_sel   = '0;
    w_ld_hz = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (r_v[k] && r_we[k] && id_rs_used[n] &&
            (id_rs[n*AW +: AW] != '0) &&
            (r_rd[k] == id_rs[n*AW +: AW])) begin
          w_sel[n*SELW +: SELW] = SELW'(k);
          w_ld_hz[n]            = r_ld[k] && (k <= LOAD_LAT);
        end
      end
    end
  end

  assign w_redir = redirect & r_v[1];
  assign w_kill  = w_redir | (r_kcnt != '0);
  assign w_stall = id_valid & ~w_kill & (|w_ld_hz);

  // Scoreboard shift; stalled or killed slots enter as bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v  <= '0;
      r_we <= '0;
      r_ld <= '0;
      for (int k = 1; k <= NUM_STAGES; k++) begin
        r_rd[k] <= '0;
      end
    end else begin
      r_v[1]  <= id_valid & ~w_stall & ~w_kill;
      r_we[1] <= id_rd_we;
      r_ld[1] <= id_is_load;
      r_rd[1] <= id_rd;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        r_v[k]  <= r_v[k-1];
        r_we[k] <= r_we[k-1];
        r_ld[k] <= r_ld[k-1];
        r_rd[k] <= r_rd[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kcnt <= '0;
    end else if (w_redir) begin
      r_kcnt <= KLOAD;
    end else if (r_kcnt != '0) begin
      r_kcnt <= r_kcnt - KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_kill && (r_kill_cnt != '1)) begin
        r_kill_cnt <= r_kill_cnt + CNT_W'(1);
      end
    end
  end

  assign stall     = w_stall;
  assign kill      = w_kill;
  assign fwd_sel   = w_sel;
  assign stall_cnt = r_stall_cnt;
  assign kill_cnt  = r_kill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_hazard_fwd_unit : directed bench, KILL_SLOTS=1 and KILL_SLOTS=3 units    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_rd_we;
  logic       id_is_load;
  logic       redirect;

  logic       a_stall, a_kill, b_stall, b_kill;
  logic [3:0] a_fwd_sel, b_fwd_sel;
  logic [3:0] a_stall_cnt, a_kill_cnt, b_stall_cnt, b_kill_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .NUM_STAGES(2), .NUM_SRC(2), .AW(5), .LOAD_LAT(1), .KILL_SLOTS(1), .CNT_W(4)
  ) u_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .redirect(redirect), .stall(a_stall),
    .kill(a_kill), .fwd_sel(a_fwd_sel), .stall_cnt(a_stall_cnt),
    .kill_cnt(a_kill_cnt)
  );

  hazard_fwd_unit #(
    .NUM_STAGES(2), .NUM_SRC(2), .AW(5), .LOAD_LAT(1), .KILL_SLOTS(3), .CNT_W(4)
  ) u_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .redirect(redirect), .stall(b_stall),
    .kill(b_kill), .fwd_sel(b_fwd_sel), .stall_cnt(b_stall_cnt),
    .kill_cnt(b_kill_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs0,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic we, input logic ld);
    id_valid   = v;
    id_rs      = {rs1, rs0};
    id_rs_used = used;
    id_rd      = rd;
    id_rd_we   = we;
    id_is_load = ld;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    instr(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // ---- reset state and ALU forwarding ----
    do_reset();
    #1;
    chk("rst_stall", a_stall, 0);
    chk("rst_kill", a_kill, 0);
    chk("rst_fwd", a_fwd_sel, 0);
    chk("rst_scnt", a_stall_cnt, 0);
    instr(1'b1, 5'd2, 5'd1, 2'b11, 5'd5, 1'b1, 1'b0);      // add x5,x1,x2
    #1 chk("add_x5_fwd", a_fwd_sel, 4'b0000);
    tick();
    instr(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);      // add x6,x5,x5
    #1 chk("fwd_x1x1", a_fwd_sel, 4'b0101);
    chk("fwd_nostall", a_stall, 0);
    tick();
    instr(1'b1, 5'd6, 5'd5, 2'b11, 5'd9, 1'b1, 1'b0);      // x5 in M, x6 in X
    #1 chk("fwd_m_x", a_fwd_sel, 4'b0110);

    // ---- load-use stall ----
    do_reset();
    instr(1'b1, 5'd0, 5'd1, 2'b01, 5'd7, 1'b1, 1'b1);      // lw x7
    tick();
    instr(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);      // add x8,x7,x7
    #1 chk("lu_stall", a_stall, 1);
    tick();
    #1 chk("lu_release", a_stall, 0);
    chk("lu_fwd_m", a_fwd_sel, 4'b1010);
    chk("lu_scnt", a_stall_cnt, 1);

    // ---- unused operand never stalls ----
    do_reset();
    instr(1'b1, 5'd0, 5'd1, 2'b01, 5'd7, 1'b1, 1'b1);      // lw x7
    tick();
    instr(1'b1, 5'd7, 5'd3, 2'b01, 5'd8, 1'b1, 1'b0);      // x7 on unused op1
    #1 chk("unused_nostall", a_stall, 0);
    chk("unused_fwd", a_fwd_sel, 4'b0000);
    instr(1'b1, 5'd3, 5'd7, 2'b01, 5'd8, 1'b1, 1'b0);      // x7 on used op0
    #1 chk("used_stall", a_stall, 1);

    // ---- redirect beats load-use ----
    do_reset();
    instr(1'b1, 5'd0, 5'd1, 2'b01, 5'd7, 1'b1, 1'b1);      // lw x7 in X next
    tick();
    instr(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
    redirect = 1'b1;
    #1 chk("redir_kill", a_kill, 1);
    chk("redir_nostall", a_stall, 0);
    tick();
    redirect = 1'b0;
    instr(1'b1, 5'd0, 5'd8, 2'b01, 5'd0, 1'b0, 1'b0);      // reader of killed x8
    #1 chk("kill_done", a_kill, 0);
    chk("kill_cnt1", a_kill_cnt, 1);
    chk("killed_bubble", a_fwd_sel, 4'b0000);
    redirect = 1'b1;                                        // entry 1 is a bubble
    #1 chk("redir_ignored", a_kill, 0);
    redirect = 1'b0;

    // ---- three-slot kill window ----
    do_reset();
    instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1, 1'b0);
    tick();
    redirect = 1'b1;
    #1 chk("k3_c1", b_kill, 1);
    tick();
    #1 chk("k3_c2", b_kill, 1);                            // redirect here is ignored
    tick();
    redirect = 1'b0;
    #1 chk("k3_c3", b_kill, 1);
    tick();
    #1 chk("k3_end", b_kill, 0);
    chk("k3_cnt", b_kill_cnt, 3);

    // ---- x0 never forwards; reset mid-stall ----
    do_reset();
    instr(1'b1, 5'd0, 5'd1, 2'b01, 5'd0, 1'b1, 1'b1);      // lw x0
    tick();
    instr(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b0);      // add x0,x0,x0
    #1 chk("x0_nostall", a_stall, 0);
    chk("x0_fwd", a_fwd_sel, 4'b0000);
    tick();
    #1 chk("x0_fwd2", a_fwd_sel, 4'b0000);
    instr(1'b1, 5'd0, 5'd1, 2'b01, 5'd7, 1'b1, 1'b1);      // lw x7
    tick();
    instr(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
    #1 chk("pre_rst_stall", a_stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("rst_mid_stall", a_stall, 0);
    chk("rst_mid_fwd", a_fwd_sel, 4'b0000);
    chk("rst_mid_scnt", a_stall_cnt, 0);

    // ---- stall counter saturation ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      instr(1'b1, 5'd0, 5'd1, 2'b00, 5'd7, 1'b1, 1'b1);
      tick();
      instr(1'b1, 5'd0, 5'd7, 2'b01, 5'd8, 1'b1, 1'b0);
      tick();
      tick();
      if (i == 14) chk("scnt_15", a_stall_cnt, 15);
    end
    chk("scnt_sat", a_stall_cnt, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
